// File: rtl/pwm_pkg.sv
// Shared types and default sizing for the PWM sample scheduler.
// The state encoding is also used by the bench to describe the expected sequencing.
package pwm_pkg;

  localparam int DUTY_W_DEF     = 8;
  localparam int FIFO_DEPTH_DEF = 16;
  localparam int PRESC_W_DEF    = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } pwm_state_t;

  // Last counter value of a period: period length is 2**w - 1 ticks.
  function automatic logic [31:0] cnt_max(input int w);
    return (32'd1 << w) - 32'd2;
  endfunction

endpackage

// File: rtl/pwm_sample_scheduler_if.sv
// Producer-side sample stream: valid/ready handshake carrying one duty value per beat.
// The producer drives the master modport; the scheduler consumes it through the slave modport.
interface pwm_sample_scheduler_if #(
  parameter int DUTY_W = 8
) ();

  logic              s_valid;
  logic              s_ready;
  logic [DUTY_W-1:0] s_duty;

  modport master (
    output s_valid,
    output s_duty,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_duty,
    output s_ready
  );

endinterface

// File: rtl/pwm_sample_scheduler_sync_fifo.sv
// Single-clock sample FIFO with first-word-fall-through read and occupancy count.
// Pointers and level reset asynchronously; the storage array is left unreset.
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q,  level_d;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);

  // A push at full is refused even when a pop happens in the same cycle.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  assign rd_data_o = mem_q[rd_ptr_q];
  assign level_o   = level_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

endmodule

// File: rtl/pwm_sample_scheduler.sv
// Streams duty samples from a FIFO into one PWM output, switching duty only on period boundaries.
// Enable drives IDLE -> PRIME -> RUN sequencing; an empty FIFO at a boundary holds the duty and flags underrun.
module pwm_sample_scheduler
  import pwm_pkg::*;
#(
  parameter int DUTY_W     = DUTY_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int PRESC_W    = PRESC_W_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic [PRESC_W-1:0]            prescale,
  pwm_sample_scheduler_if.slave         s_if,
  output logic                          pwm_out,
  output logic                          period_tick,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          busy
);

  localparam logic [DUTY_W-1:0] CNT_MAX = DUTY_W'(cnt_max(DUTY_W));

  pwm_state_t         state_q, state_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;
  logic [DUTY_W-1:0]  cnt_q, cnt_d;
  logic [DUTY_W-1:0]  active_duty_q, active_duty_d;
  logic               pwm_q, pwm_d;

  logic               fifo_push;
  logic               fifo_pop;
  logic [DUTY_W-1:0]  fifo_rd_data;
  logic               fifo_full;
  logic               fifo_empty;
  logic               tick;
  logic               boundary;

  assign s_if.s_ready = !fifo_full;
  assign fifo_push    = s_if.s_valid && !fifo_full;

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DUTY_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_i    (fifo_push),
    .wr_data_i (s_if.s_duty),
    .pop_i     (fifo_pop),
    .rd_data_o (fifo_rd_data),
    .level_o   (fifo_level),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign tick     = (presc_cnt_q == presc_q);
  assign boundary = (state_q == RUN) && tick && (cnt_q == CNT_MAX);
  assign busy     = (state_q != IDLE);
  assign pwm_out  = pwm_q;

  always_comb begin
    state_d       = state_q;
    presc_d       = presc_q;
    presc_cnt_d   = presc_cnt_q;
    cnt_d         = cnt_q;
    active_duty_d = active_duty_q;
    fifo_pop      = 1'b0;
    period_tick   = 1'b0;
    underrun      = 1'b0;

    case (state_q)
      IDLE: begin
        presc_cnt_d = '0;
        cnt_d       = '0;
        if (enable) begin
          presc_d = prescale;
          state_d = PRIME;
        end
      end

      PRIME: begin
        presc_cnt_d = '0;
        cnt_d       = '0;
        if (!fifo_empty) begin
          fifo_pop      = 1'b1;
          active_duty_d = fifo_rd_data;
          state_d       = RUN;
        end else if (!enable) begin
          state_d = IDLE;
        end
      end

      RUN: begin
        if (tick) begin
          presc_cnt_d = '0;
          cnt_d       = (cnt_q == CNT_MAX) ? '0 : cnt_q + DUTY_W'(1);
        end else begin
          presc_cnt_d = presc_cnt_q + PRESC_W'(1);
        end
        // Enable is only acted on here, so a period is never cut short.
        if (boundary) begin
          period_tick = 1'b1;
          if (!enable) begin
            state_d = IDLE;
          end else if (!fifo_empty) begin
            fifo_pop      = 1'b1;
            active_duty_d = fifo_rd_data;
          end else begin
            underrun = 1'b1;
          end
        end
      end

      default: begin
        state_d     = IDLE;
        presc_cnt_d = '0;
        cnt_d       = '0;
      end
    endcase
  end

  // The output flop is fed from next-state values so pwm_out matches this cycle's cnt/duty registers.
  assign pwm_d = (state_d == RUN) && (cnt_d < active_duty_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      presc_q       <= '0;
      presc_cnt_q   <= '0;
      cnt_q         <= '0;
      active_duty_q <= '0;
      pwm_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      presc_q       <= presc_d;
      presc_cnt_q   <= presc_cnt_d;
      cnt_q         <= cnt_d;
      active_duty_q <= active_duty_d;
      pwm_q         <= pwm_d;
    end
  end

endmodule

// File: tb/tb_pwm_sample_scheduler.sv
// Directed bench for pwm_sample_scheduler: duty shapes, extremes, underrun, stop, backpressure, reset.
// Outputs are sampled 1 ns after each rising edge; expected values are hand-derived constants.
`timescale 1ns/1ps
module tb_pwm_sample_scheduler;

  localparam int DUTY_W     = 8;
  localparam int FIFO_DEPTH = 16;
  localparam int PRESC_W    = 8;

  logic               clk;
  logic               rst_n;
  logic               enable;
  logic [PRESC_W-1:0] prescale;
  logic               pwm_out;
  logic               period_tick;
  logic               underrun;
  logic [4:0]         fifo_level;
  logic               busy;

  int n_cmp;
  int n_err;

  pwm_sample_scheduler_if #(.DUTY_W(DUTY_W)) s_if ();

  pwm_sample_scheduler #(
    .DUTY_W     (DUTY_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .PRESC_W    (PRESC_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .prescale    (prescale),
    .s_if        (s_if),
    .pwm_out     (pwm_out),
    .period_tick (period_tick),
    .underrun    (underrun),
    .fifo_level  (fifo_level),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end else begin
      $display("  ok  %s: %0d", tag, obs);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DUTY_W-1:0] d);
    s_if.s_valid = 1'b1;
    s_if.s_duty  = d;
    step();
    s_if.s_valid = 1'b0;
  endtask

  // Observe n cycles starting with the current one; optionally drop enable at index drop_at.
  task automatic measure(input int n, input int drop_at,
                         output int highs, output int ticks, output int unders,
                         output int tick_pos, output int under_pos);
    highs = 0; ticks = 0; unders = 0; tick_pos = -1; under_pos = -1;
    for (int i = 0; i < n; i++) begin
      if (i == drop_at) enable = 1'b0;
      if (pwm_out) highs++;
      if (period_tick) begin
        ticks++;
        if (tick_pos < 0) tick_pos = i;
      end
      if (underrun) begin
        unders++;
        if (under_pos < 0) under_pos = i;
      end
      step();
    end
  endtask

  task automatic start_run();
    enable = 1'b1;
    step();
    step();
  endtask

  task automatic stop_and_wait(input string tag);
    int k;
    enable = 1'b0;
    k = 0;
    while (busy && k < 600) begin
      step();
      k++;
    end
    check(tag, busy, 0);
  endtask

  int hi, tk, un, tpos, upos;

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    enable = 1'b0;
    prescale = '0;
    s_if.s_valid = 1'b0;
    s_if.s_duty = '0;
    #1;
    check("rst_pwm", pwm_out, 0);
    check("rst_busy", busy, 0);
    check("rst_level", fifo_level, 0);
    check("rst_ready", s_if.s_ready, 1);
    check("rst_ptick", period_tick, 0);
    check("rst_under", underrun, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    step();

    // T2: duty 64 then 192
    push(8'd64);
    push(8'd192);
    check("t2_level", fifo_level, 2);
    start_run();
    check("t2_first_pwm", pwm_out, 1);
    measure(255, -1, hi, tk, un, tpos, upos);
    check("t2_p1_high", hi, 64);
    check("t2_p1_ticks", tk, 1);
    check("t2_p1_tpos", tpos, 254);
    check("t2_p1_under", un, 0);
    measure(255, 100, hi, tk, un, tpos, upos);
    check("t2_p2_high", hi, 192);
    check("t2_p2_tpos", tpos, 254);
    check("t2_p2_under", un, 0);
    check("t2_idle", busy, 0);

    // T3: extremes 0 and 255
    push(8'd0);
    push(8'd255);
    start_run();
    measure(255, -1, hi, tk, un, tpos, upos);
    check("t3_zero_high", hi, 0);
    measure(255, 5, hi, tk, un, tpos, upos);
    check("t3_full_high", hi, 255);
    check("t3_full_tick", tk, 1);
    check("t3_idle", busy, 0);

    // T4: underrun at the 2nd boundary, duty held afterwards
    push(8'd77);
    push(8'd33);
    start_run();
    measure(255, -1, hi, tk, un, tpos, upos);
    check("t4_p1_high", hi, 77);
    check("t4_p1_under", un, 0);
    measure(255, -1, hi, tk, un, tpos, upos);
    check("t4_p2_high", hi, 33);
    check("t4_p2_under", un, 1);
    check("t4_p2_upos", upos, 254);
    measure(255, 0, hi, tk, un, tpos, upos);
    check("t4_p3_held", hi, 33);
    check("t4_p3_under", un, 0);
    check("t4_idle", busy, 0);

    // Prescale 1: period doubles; a change after the latch is ignored
    prescale = 8'd1;
    push(8'd50);
    enable = 1'b1;
    step();
    prescale = 8'd0;
    step();
    measure(510, 300, hi, tk, un, tpos, upos);
    check("ps_high", hi, 100);
    check("ps_tpos", tpos, 509);
    check("ps_idle", busy, 0);

    // T6: backpressure at full
    s_if.s_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      s_if.s_duty = 8'(100 + i);
      step();
    end
    check("t6_full_level", fifo_level, 16);
    check("t6_full_ready", s_if.s_ready, 0);
    s_if.s_duty = 8'd200;
    step();
    step();
    check("t6_wait_level", fifo_level, 16);
    enable = 1'b1;
    step();
    check("t6_prime_ready", s_if.s_ready, 0);
    step();
    check("t6_pop_level", fifo_level, 15);
    check("t6_pop_ready", s_if.s_ready, 1);
    step();
    s_if.s_valid = 1'b0;
    check("t6_accept_level", fifo_level, 16);

    // T1: async reset mid-RUN (duty 100, cnt small)
    step();
    step();
    check("t1_pre_pwm", pwm_out, 1);
    rst_n = 1'b0;
    enable = 1'b0;
    #1;
    check("t1_pwm", pwm_out, 0);
    check("t1_busy", busy, 0);
    check("t1_level", fifo_level, 0);
    check("t1_ready", s_if.s_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // T5: stop at cnt=10, finish period, resume from next sample
    push(8'd10);
    push(8'd20);
    push(8'd30);
    start_run();
    check("t5_level_run", fifo_level, 2);
    measure(255, 10, hi, tk, un, tpos, upos);
    check("t5_p1_high", hi, 10);
    check("t5_p1_tpos", tpos, 254);
    check("t5_p1_under", un, 0);
    check("t5_idle", busy, 0);
    check("t5_level_kept", fifo_level, 2);
    start_run();
    measure(255, 100, hi, tk, un, tpos, upos);
    check("t5_resume_high", hi, 20);
    check("t5_idle2", busy, 0);
    check("t5_level_end", fifo_level, 1);
    stop_and_wait("t5_final_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
